// File: rtl/tdc_pkg.sv
// Shared FSM encodings and width helpers for the delay-line TDC front end.
// Pure declarations and constant functions.
package tdc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_LAUNCH   = 3'd1;
  localparam state_t ST_CAPTURE  = 3'd2;
  localparam state_t ST_SYNC     = 3'd3;
  localparam state_t ST_ACCUM    = 3'd4;
  localparam state_t ST_SETTLE_W = 3'd5;
  localparam state_t ST_DONE     = 3'd6;

  // Code width able to hold 0..n inclusive.
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int acc_w(input int n, input int max_avg_log2);
    return cw_of(n) + max_avg_log2;
  endfunction

  function automatic int clamp_avg(input int v, input int max_avg_log2);
    return (v > max_avg_log2) ? max_avg_log2 : v;
  endfunction

endpackage

// File: rtl/delay_line.sv
// Tapped delay line; RTL stand-in whose real cells are placed by the physical flow.
// Combinational, no backpressure; taps[i] follows `in` after i stages.
module delay_line #(
  parameter int    N       = 64,
  parameter string DL_TYPE = "RCA"
) (
  input  logic         in,
  output logic [N-1:0] taps
);

  localparam logic OP_A = 1'b1;
  localparam logic OP_B = 1'b0;

  generate
    if (DL_TYPE == "RCA") begin : g_rca
      // Carry chain with a=1, b=0: every stage propagates the carry-in.
      always_comb begin
        logic c;
        c    = in;
        taps = '0;
        for (int i = 0; i < N; i++) begin
          c       = (OP_A & OP_B) | ((OP_A ^ OP_B) & c);
          taps[i] = c;
        end
      end
    end else begin : g_buf
      always_comb begin
        taps = '0;
        for (int i = 0; i < N; i++) taps[i] = in;
      end
    end
  endgenerate

endmodule

// File: rtl/tdc_therm_encoder.sv
// Bubble-corrected thermometer-to-count encoder with raw all-set/none-set flags.
// Purely combinational, no backpressure.
module tdc_therm_encoder
  import tdc_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0]         taps,
  output logic [cw_of(N)-1:0]  code,
  output logic                 ovf,
  output logic                 unf
);

  localparam int CW = cw_of(N);

  // Padded so tap i sees ext[i] (below), ext[i+1] (itself), ext[i+2] (above).
  logic [N+1:0] ext;
  assign ext = {1'b0, taps, 1'b1};

  always_comb begin
    code = '0;
    for (int i = 0; i < N; i++) begin
      if ((ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]))
        code = code + CW'(1);
    end
  end

  assign ovf = &taps;
  assign unf = ~|taps;

endmodule

// File: rtl/tdc_sampler.sv
// Multi-channel delay-line TDC: launch, capture, sync, encode, average over 2^k shots.
// Single shot valid 5 clocks after start; result held until res_valid && res_ready.
module tdc_sampler
  import tdc_pkg::*;
#(
  parameter int    N            = 64,
  parameter int    CH           = 4,
  parameter string DL_TYPE      = "RCA",
  parameter int    MAX_AVG_LOG2 = 4,
  parameter int    SETTLE       = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [$clog2(MAX_AVG_LOG2+1)-1:0] avg_log2,
  output logic                              busy,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [CH*cw_of(N)-1:0]            res_code,
  output logic [CH-1:0]                     res_ovf,
  output logic [CH-1:0]                     res_unf
);

  localparam int CW   = cw_of(N);
  localparam int AW   = $clog2(MAX_AVG_LOG2 + 1);
  localparam int ACCW = acc_w(N, MAX_AVG_LOG2);
  localparam int SCW  = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;
  localparam int LW   = $clog2(SETTLE + 2);

  state_t          state;
  logic            launch;
  logic [AW-1:0]   avg_q;
  logic [SCW-1:0]  shot_cnt;
  logic [LW-1:0]   low_cnt;
  logic [CH*N-1:0] line_taps;
  logic [CH*N-1:0] cap_q;
  logic [CH*N-1:0] sync_q;
  logic [ACCW-1:0] acc [CH];
  logic [CH-1:0]   ovf_acc;
  logic [CH-1:0]   unf_acc;
  logic [CW-1:0]   enc_code [CH];
  logic [CH-1:0]   enc_ovf;
  logic [CH-1:0]   enc_unf;

  logic settle_ok;
  logic settle_last;
  logic shot_last;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    (* keep *) delay_line #(
      .N       (N),
      .DL_TYPE (DL_TYPE)
    ) u_dl (
      .in   (launch),
      .taps (line_taps[c*N +: N])
    );

    tdc_therm_encoder #(
      .N (N)
    ) u_enc (
      .taps (sync_q[c*N +: N]),
      .code (enc_code[c]),
      .ovf  (enc_ovf[c]),
      .unf  (enc_unf[c])
    );
  end

  // Clocks the line has spent discharged; reset starts it at zero so the
  // first launch after reset still waits out the full settle time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      low_cnt <= '0;
    else if (launch)
      low_cnt <= '0;
    else if (int'(low_cnt) < SETTLE)
      low_cnt <= low_cnt + LW'(1);
  end

  assign settle_ok   = (int'(low_cnt) >= SETTLE);
  assign settle_last = (int'(low_cnt) + 1 >= SETTLE);
  assign shot_last   = (shot_cnt == SCW'((1 << avg_q) - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      launch    <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_code  <= '0;
      res_ovf   <= '0;
      res_unf   <= '0;
      avg_q     <= '0;
      shot_cnt  <= '0;
      ovf_acc   <= '0;
      unf_acc   <= '0;
      cap_q     <= '0;
      sync_q    <= '0;
      for (int c = 0; c < CH; c++) acc[c] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            avg_q    <= AW'(clamp_avg(int'(avg_log2), MAX_AVG_LOG2));
            shot_cnt <= '0;
            ovf_acc  <= '0;
            unf_acc  <= '0;
            res_code <= '0;
            res_ovf  <= '0;
            res_unf  <= '0;
            busy     <= 1'b1;
            for (int c = 0; c < CH; c++) acc[c] <= '0;
            state    <= settle_ok ? ST_LAUNCH : ST_SETTLE_W;
          end
        end
        ST_LAUNCH: begin
          launch <= 1'b1;
          state  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          cap_q <= line_taps;
          state <= ST_SYNC;
        end
        ST_SYNC: begin
          sync_q <= cap_q;
          state  <= ST_ACCUM;
        end
        ST_ACCUM: begin
          for (int c = 0; c < CH; c++) acc[c] <= acc[c] + ACCW'(enc_code[c]);
          ovf_acc <= ovf_acc | enc_ovf;
          unf_acc <= unf_acc | enc_unf;
          launch  <= 1'b0;
          if (shot_last) begin
            state <= ST_DONE;
          end else begin
            shot_cnt <= shot_cnt + SCW'(1);
            state    <= ST_SETTLE_W;
          end
        end
        ST_SETTLE_W: begin
          if (settle_last) state <= ST_LAUNCH;
        end
        ST_DONE: begin
          if (!res_valid) begin
            res_valid <= 1'b1;
            res_ovf   <= ovf_acc;
            res_unf   <= unf_acc;
            for (int c = 0; c < CH; c++) res_code[c*CW +: CW] <= CW'(acc[c] >> avg_q);
          end else if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_sampler.sv
// Directed bench for tdc_sampler: line taps are forced to hand-built thermometer
// patterns and each result is compared against hand-computed codes and flags.
module tb_tdc_sampler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  avg_log2;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [27:0] res_code;
  logic [3:0]  res_ovf;
  logic [3:0]  res_unf;

  int checks = 0;
  int errors = 0;
  logic [255:0] line_pat;

  tdc_sampler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .avg_log2  (avg_log2),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_code  (res_code),
    .res_ovf   (res_ovf),
    .res_unf   (res_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] therm(input int k);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) if (i < k) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    logic [27:0] v;
    v = {7'(d), 7'(c), 7'(b), 7'(a)};
    return 64'(v);
  endfunction

  task automatic set_taps(input logic [63:0] t0, input logic [63:0] t1,
                          input logic [63:0] t2, input logic [63:0] t3);
    line_pat = {t3, t2, t1, t0};
    force dut.line_taps = line_pat;
  endtask

  task automatic do_start(input logic [2:0] a);
    @(negedge clk);
    start    = 1'b1;
    avg_log2 = a;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  task automatic wait_valid(input int lim, input string tag);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < lim) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(res_valid), 64'd1);
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
    chk({tag, "_busy_drop"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    avg_log2  = 3'd0;
    res_ready = 1'b0;
    set_taps('0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_code", 64'(res_code), 64'd0);
    chk("rst_ovf", 64'(res_ovf), 64'd0);
    chk("rst_unf", 64'(res_unf), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single shot: 23 taps, bubble pattern, all set, none set.
    set_taps(therm(23), 64'h13DF, therm(64), therm(0));
    do_start(3'd0);
    @(negedge clk);
    chk("s1_busy", 64'(busy), 64'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("s1_valid_c4", 64'(res_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("s1_valid_c5", 64'(res_valid), 64'd1);
    chk("s1_code", 64'(res_code), pack4(23, 10, 64, 0));
    chk("s1_ovf", 64'(res_ovf), 64'h4);
    chk("s1_unf", 64'(res_unf), 64'h8);
    handshake("s1");

    // Four-shot average with sticky flags; patterns change between captures.
    set_taps(therm(20), therm(40), therm(0), therm(64));
    do_start(3'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_taps(therm(21), therm(40), therm(64), therm(5));
    repeat (6) @(posedge clk);
    @(negedge clk);
    set_taps(therm(22), therm(40), therm(64), therm(5));
    repeat (6) @(posedge clk);
    @(negedge clk);
    set_taps(therm(23), therm(40), therm(64), therm(6));
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("avg_valid_c22", 64'(res_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("avg_valid_c23", 64'(res_valid), 64'd1);
    chk("avg_code", 64'(res_code), pack4(21, 40, 48, 20));
    chk("avg_ovf", 64'(res_ovf), 64'hC);
    chk("avg_unf", 64'(res_unf), 64'h4);
    handshake("avg");

    // avg_log2 above the maximum clamps to 16 shots.
    set_taps(therm(9), therm(17), therm(33), therm(1));
    do_start(3'd7);
    repeat (94) @(posedge clk);
    @(negedge clk);
    chk("clamp_valid_c94", 64'(res_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("clamp_valid_c95", 64'(res_valid), 64'd1);
    chk("clamp_code", 64'(res_code), pack4(9, 17, 33, 1));
    chk("clamp_ovf", 64'(res_ovf), 64'h0);
    chk("clamp_unf", 64'(res_unf), 64'h0);

    // Backpressure: result holds, and a start while busy is dropped.
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        start    = 1'b1;
        avg_log2 = 3'd1;
      end
      set_taps(therm(50), therm(50), therm(50), therm(50));
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("bp_valid_hold", 64'(res_valid), 64'd1);
      chk("bp_code_hold", 64'(res_code), pack4(9, 17, 33, 1));
    end
    chk("bp_busy_hold", 64'(busy), 64'd1);
    handshake("bp");
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp_start_ignored_busy", 64'(busy), 64'd0);
    chk("bp_start_ignored_valid", 64'(res_valid), 64'd0);

    // Reset while waiting out the settle time between shots.
    set_taps(therm(30), therm(30), therm(30), therm(30));
    do_start(3'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_valid", 64'(res_valid), 64'd0);
    chk("mid_code", 64'(res_code), 64'd0);
    chk("mid_ovf_unf", {56'd0, res_ovf, res_unf}, 64'd0);
    chk("mid_launch", 64'(dut.launch), 64'd0);
    chk("mid_state", 64'(dut.state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_taps(therm(31), 64'h13DF, therm(1), therm(63));
    do_start(3'd0);
    @(negedge clk);
    chk("post_busy", 64'(busy), 64'd1);
    wait_valid(40, "post_valid");
    chk("post_code", 64'(res_code), pack4(31, 10, 1, 63));
    chk("post_ovf", 64'(res_ovf), 64'h0);
    chk("post_unf", 64'(res_unf), 64'h0);
    handshake("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
